// File: rtl/mem_op_sequencer_pkg.sv
// Shared encodings for the multicycle memory-operation sequencer:
// opcodes, FSM states and the byte-lane index width helper.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        OP_RD_WORD = 2'b00,
        OP_WR_WORD = 2'b01,
        OP_ST_BYTE = 2'b10,
        OP_XCHG    = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_RD_B   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_WR_A   = 3'd5,
        ST_WR_B   = 3'd6,
        ST_DONE   = 3'd7
    } state_t;

    localparam int MAX_MEM_LAT = 8;

    // Number of address bits needed to pick one byte lane out of a word.
    function automatic int lane_idx_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_op_sequencer_byte_lane_merge.sv
// Combinational byte insert: replaces one little-endian byte lane of a word
// (lane 0 = bits [7:0]) with an 8-bit value.
module byte_lane_merge
    import mem_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = lane_idx_w(DATA_W)
) (
    input  logic [DATA_W-1:0] word,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_val,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = word;
        for (int i = 0; i < DATA_W / 8; i++) begin
            if (lane == LANE_W'(i)) begin
                merged[8*i +: 8] = byte_val;
            end
        end
    end

endmodule

// File: rtl/mem_op_sequencer.sv
// Multicycle memory-operation sequencer: word read/write, byte read-modify-write
// and atomic exchange over a single-port memory with configurable read latency.
module mem_op_sequencer
    import mem_seq_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LANE_W = lane_idx_w(DATA_W);
    localparam int CNT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t            state;
    state_t            next_state;
    op_t               op_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] tmp_a;
    logic [DATA_W-1:0] tmp_b;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] merged;
    logic              last_wait;
    logic              same_addr;

    assign last_wait = (cnt == '0);
    assign same_addr = (a_q == b_q);

    byte_lane_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .word     (tmp_a),
        .lane     (a_q[LANE_W-1:0]),
        .byte_val (wdata_q[7:0]),
        .merged   (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = (op_t'(op) == OP_WR_WORD) ? ST_WR_A : ST_RD_A;
                end
            end
            ST_RD_A:   next_state = ST_WAIT_A;
            ST_WAIT_A: begin
                if (last_wait) begin
                    unique case (op_q)
                        OP_ST_BYTE: next_state = ST_WR_A;
                        OP_XCHG:    next_state = same_addr ? ST_DONE : ST_RD_B;
                        default:    next_state = ST_DONE;
                    endcase
                end
            end
            ST_RD_B:   next_state = ST_WAIT_B;
            ST_WAIT_B: next_state = last_wait ? ST_WR_A : ST_WAIT_B;
            ST_WR_A:   next_state = (op_q == OP_XCHG) ? ST_WR_B : ST_DONE;
            ST_WR_B:   next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Address and write data stay zero outside strobe cycles.
    always_comb begin
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            ST_RD_A: begin
                mem_rd   = 1'b1;
                mem_addr = a_q;
            end
            ST_RD_B: begin
                mem_rd   = 1'b1;
                mem_addr = b_q;
            end
            ST_WR_A: begin
                mem_wr   = 1'b1;
                mem_addr = a_q;
                unique case (op_q)
                    OP_ST_BYTE: mem_wdata = merged;
                    OP_XCHG:    mem_wdata = tmp_b;
                    default:    mem_wdata = wdata_q;
                endcase
            end
            ST_WR_B: begin
                mem_wr    = 1'b1;
                mem_addr  = b_q;
                mem_wdata = tmp_a;
            end
            default: ;
        endcase
    end

    // rdata_out is loaded straight from mem_rdata on the final wait cycle because
    // tmp_a only becomes valid on that same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_RD_WORD;
            a_q       <= '0;
            b_q       <= '0;
            wdata_q   <= '0;
            tmp_a     <= '0;
            tmp_b     <= '0;
            cnt       <= '0;
            rdata_out <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op_t'(op);
                        a_q     <= addr_a;
                        b_q     <= addr_b;
                        wdata_q <= wdata;
                    end
                end
                ST_RD_A, ST_RD_B: cnt <= CNT_LOAD;
                ST_WAIT_A: begin
                    if (last_wait) begin
                        tmp_a <= mem_rdata;
                        if (op_q == OP_RD_WORD || (op_q == OP_XCHG && same_addr)) begin
                            rdata_out <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WAIT_B: begin
                    if (last_wait) begin
                        tmp_b <= mem_rdata;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WR_B: rdata_out <= tmp_a;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_op_sequencer.md
Name: mem_op_sequencer

Overview:
Parametrised multicycle memory-operation sequencer that replaces the hard-coded XCHG and SB read-modify-write sequences inside the processor control FSM. The control unit pulses `start` with an opcode and operands. This block then drives the single-port memory for a configurable read latency and reports completion with `done`. It supports word read, word write, byte read-modify-write store and atomic exchange, and it sits between the control unit/datapath and the memory.

Parameters:
DATA_W, 32, memory word width; must be a multiple of 8 and at least 16.
ADDR_W, 32, byte address width.
MEM_LAT, 1, cycles from the `mem_rd` issue cycle to the cycle in which `mem_rdata` is captured; legal range 1..8.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request strobe; sampled only in IDLE
op  in  2  00 RD_WORD, 01 WR_WORD, 10 ST_BYTE, 11 XCHG
addr_a  in  ADDR_W  primary address (rs)
addr_b  in  ADDR_W  second address, used by XCHG only (rt)
wdata  in  DATA_W  write data; ST_BYTE uses bits [7:0]
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
rdata_out  out  DATA_W  RD_WORD: Mem[a]; XCHG: original Mem[a]; other ops: unchanged
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rd  out  1  read issue, one cycle per read
mem_wr  out  1  write strobe, one cycle per write
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, immediate): state IDLE. `busy`, `done`, `mem_rd`, `mem_wr`, `mem_addr`, `mem_wdata` and `rdata_out` all go to 0, plus internal latches and the latency counter.
- Reset mid-operation aborts at once. No further memory strobes are issued, and a partial XCHG is not rolled back.
- States: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR_A, WR_B, DONE.
- In IDLE, `start`=1 captures `op`, `addr_a`, `addr_b` and `wdata` into registers. Later input changes are ignored until DONE. `start` is ignored while `busy`=1.
- Next state from IDLE: RD_WORD, ST_BYTE and XCHG go to RD_A; WR_WORD goes to WR_A.
- RD_A / RD_B: `mem_rd`=1 for one cycle, `mem_addr` = latched a / b.
- WAIT_x holds for MEM_LAT cycles using a down-counter loaded in RD_x. `mem_rdata` is captured on the last WAIT cycle: into tmp_a at WAIT_A, into tmp_b at WAIT_B.
- WAIT_A exit:
  - RD_WORD: load `rdata_out` from tmp_a, go to DONE.
  - ST_BYTE: go to WR_A.
  - XCHG with a==b: load `rdata_out`, go to DONE (no writes).
  - XCHG otherwise: go to RD_B.
- WAIT_B exit goes to WR_A.
- WR_A: `mem_wr`=1, `mem_addr`=a. Write data by op:
  - WR_WORD: wdata.
  - ST_BYTE: tmp_a with byte lane a[log2(DATA_W/8)-1:0] replaced by wdata[7:0]; little-endian, lane 0 = bits [7:0].
  - XCHG: tmp_b.
- WR_A exit: XCHG goes to WR_B; other ops go to DONE.
- WR_B: `mem_wr`=1, `mem_addr`=b, `mem_wdata`=tmp_a. For XCHG, `rdata_out` loads tmp_a. Next state DONE.
- DONE: `done`=1 for one cycle, `busy` stays 1, next state IDLE. A new `start` is accepted the following cycle.
- `mem_addr` and `mem_wdata` are 0 whenever `mem_rd`=`mem_wr`=0. `mem_rd` and `mem_wr` are never high together.
- Start-to-done latency, counting the start cycle as cycle 0, `done` high in cycle:
  - WR_WORD: 2.
  - RD_WORD: 2+MEM_LAT.
  - ST_BYTE: 3+MEM_LAT.
  - XCHG: 5+2*MEM_LAT.
  - XCHG with a==b: 2+MEM_LAT.
- Addresses pass through unmodified; memory ignores the low bits for word access.

Decomposition:
- Package `mem_seq_pkg`: op encodings (OP_RD_WORD, OP_WR_WORD, OP_ST_BYTE, OP_XCHG), state encoding, and a localparam function for the lane-index width.
- Sub-module `byte_lane_merge`: combinational insert of an 8-bit value into a DATA_W word at a given lane index. Parametrised on DATA_W and used in WR_A.

Test Plan:
- MEM_LAT=1, Mem[0x10]=0xAABBCCDD, RD_WORD a=0x10 → `mem_rd` in cycle 1, `done` in cycle 3, `rdata_out`=0xAABBCCDD, no `mem_wr` at any point.
- WR_WORD a=0x20, wdata=0x12345678 → `mem_wr` in cycle 1, `done` in cycle 2, Mem[0x20]=0x12345678.
- Mem[0x30]=0x11223344, ST_BYTE a=0x32, wdata=0xEE → Mem[0x30]=0x11EE3344; repeat with a=0x33 → 0xEEEE3344.
- MEM_LAT=1 and MEM_LAT=3, Mem[0x40]=0xA, Mem[0x44]=0xB, XCHG a=0x40 b=0x44 → Mem[0x40]=0xB, Mem[0x44]=0xA, `rdata_out`=0xA, `done` in cycle 7 and 11 respectively.
- XCHG a=b=0x50 → zero `mem_wr` pulses, `done` in cycle 2+MEM_LAT, memory unchanged.
- `start` pulsed while `busy`=1 is ignored. `reset` asserted during WAIT_B of an XCHG drives all outputs to 0 immediately, leaves Mem[a] and Mem[b] untouched, and a following RD_WORD completes normally.
